// File: rtl/div_int.sv
// +--------------------------------------------------------------------------+
// | Module   : div_int                                                       |
// | Purpose  : Iterative signed/unsigned integer divider (restoring).        |
// |            Define DIVINT_EARLY_EXIT_EN to finish |a| < |b| in one cycle. |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module div_int #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             valid,
    output logic             dbz,
    output logic             ovf,
    output logic [WIDTH-1:0] val,
    output logic [WIDTH-1:0] rem
);

    localparam int c_CNT_W = $clog2(WIDTH);

    localparam logic [1:0] c_KIND_NORM  = 2'd0;
    localparam logic [1:0] c_KIND_DBZ   = 2'd1;
    localparam logic [1:0] c_KIND_OVF   = 2'd2;
    localparam logic [1:0] c_KIND_EARLY = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_kind;
    logic [c_CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_q;
    logic [WIDTH-1:0]   r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_busy;
    logic               r_done;
    logic               r_valid;
    logic               r_dbz;
    logic               r_ovf;
    logic [WIDTH-1:0]   r_val;
    logic [WIDTH-1:0]   r_rem;

    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic               w_b_zero;
    logic               w_ovf;
    logic               w_early;
    logic [WIDTH:0]     w_acc;
    logic [WIDTH:0]     w_diff;

    // Operand magnitudes; the most-negative value maps onto its unsigned twin.
    assign w_ma     = (sgn && a[WIDTH-1]) ? -a : a;
    assign w_mb     = (sgn && b[WIDTH-1]) ? -b : b;
    assign w_b_zero = (b == '0);
    assign w_ovf    = sgn && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

`ifdef DIVINT_EARLY_EXIT_EN
    assign w_early  = (w_ma < w_mb);
`else
    assign w_early  = 1'b0;
`endif

    // Trial subtraction on the WIDTH+1-bit accumulator; MSB set means borrow.
    assign w_acc  = {r_acc, r_q[WIDTH-1]};
    assign w_diff = w_acc - {1'b0, r_div};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_kind  <= c_KIND_NORM;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_div   <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_dbz   <= 1'b0;
            r_ovf   <= 1'b0;
            r_val   <= '0;
            r_rem   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_valid <= 1'b0;
                        r_dbz   <= 1'b0;
                        r_ovf   <= 1'b0;
                        r_q     <= w_ma;
                        r_div   <= w_mb;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_neg_q <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg_r <= sgn && a[WIDTH-1];
                        r_state <= CALC;
                        if (w_b_zero) begin
                            r_kind <= c_KIND_DBZ;
                        end else if (w_ovf) begin
                            r_kind <= c_KIND_OVF;
                        end else if (w_early) begin
                            r_kind <= c_KIND_EARLY;
                        end else begin
                            r_kind <= c_KIND_NORM;
                            r_busy <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    if (r_kind != c_KIND_NORM) begin
                        // Short operations finish one cycle after start, busy never raised.
                        r_state <= IDLE;
                        r_done  <= 1'b1;
                        case (r_kind)
                            c_KIND_DBZ: r_dbz <= 1'b1;
                            c_KIND_OVF: r_ovf <= 1'b1;
                            default: begin
                                r_valid <= 1'b1;
                                r_val   <= '0;
                                r_rem   <= r_neg_r ? -r_q : r_q;
                            end
                        endcase
                    end else begin
                        if (!w_diff[WIDTH]) begin
                            r_acc <= w_diff[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b1};
                        end else begin
                            r_acc <= w_acc[WIDTH-1:0];
                            r_q   <= {r_q[WIDTH-2:0], 1'b0};
                        end
                        r_cnt <= r_cnt + c_CNT_W'(1);
                        if (r_cnt == c_CNT_W'(WIDTH-1)) begin
                            r_state <= SIGN;
                        end
                    end
                end
                SIGN: begin
                    r_val   <= r_neg_q ? -r_q : r_q;
                    r_rem   <= r_neg_r ? -r_acc : r_acc;
                    r_valid <= 1'b1;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy  = r_busy;
    assign done  = r_done;
    assign valid = r_valid;
    assign dbz   = r_dbz;
    assign ovf   = r_ovf;
    assign val   = r_val;
    assign rem   = r_rem;

endmodule

`default_nettype wire

// File: tb/tb_div_int.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_div_int                                                    |
// | Purpose  : Directed self-checking bench for div_int (WIDTH = 8).         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_div_int;

    localparam int WIDTH = 8;

`ifdef DIVINT_EARLY_EXIT_EN
    localparam int c_SMALL_LAT = 1;
`else
    localparam int c_SMALL_LAT = 9;
`endif

    logic             clk;
    logic             rst;
    logic             start;
    logic             sgn;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             valid;
    logic             dbz;
    logic             ovf;
    logic [WIDTH-1:0] val;
    logic [WIDTH-1:0] rem;

    int n_chk;
    int n_err;
    int lat;
    logic busy1;
    logic seen;

    div_int #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .sgn   (sgn),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .valid (valid),
        .dbz   (dbz),
        .ovf   (ovf),
        .val   (val),
        .rem   (rem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one start, count edges until done (bounded). When intr_at > 0 a
    // second start (9/3) is driven after edge intr_at of the running op.
    task automatic run_op(input logic s, input logic [7:0] aa, input logic [7:0] bb,
                          input int intr_at, output int l, output logic b1);
        start = 1'b1; sgn = s; a = aa; b = bb;
        @(posedge clk); #1;
        start = 1'b0;
        l  = 0;
        b1 = 1'b0;
        while (l < 40) begin
            @(posedge clk); #1;
            l++;
            if (l == 1) b1 = busy;
            if (done) break;
            if (l == intr_at) begin
                start = 1'b1; sgn = 1'b0; a = 8'd9; b = 8'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    task automatic check_pulse(input string tag);
        @(posedge clk); #1;
        check(tag, {31'd0, done}, 32'd0);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_flags", {30'd0, dbz, ovf}, 32'd0);
        check("rst_val",   {24'd0, val}, 32'd0);
        check("rst_rem",   {24'd0, rem}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 200 / 7 unsigned
        run_op(1'b0, 8'd200, 8'd7, 0, lat, busy1);
        check("u200_7_lat",   lat, 32'd9);
        check("u200_7_busy",  {31'd0, busy1}, 32'd1);
        check("u200_7_val",   {24'd0, val}, 32'd28);
        check("u200_7_rem",   {24'd0, rem}, 32'd4);
        check("u200_7_valid", {31'd0, valid}, 32'd1);
        check("u200_7_flags", {30'd0, dbz, ovf}, 32'd0);
        check_pulse("u200_7_pulse");
        check("u200_7_hold",  {23'd0, valid, val}, {23'd0, 1'b1, 8'd28});

        // -7 / 2 signed, then same bits unsigned
        run_op(1'b1, 8'hF9, 8'd2, 0, lat, busy1);
        check("s_m7_2_val", {24'd0, val}, 32'hFD);
        check("s_m7_2_rem", {24'd0, rem}, 32'hFF);
        run_op(1'b1, 8'hF9, 8'hFE, 0, lat, busy1);
        check("s_m7_m2_val", {24'd0, val}, 32'd3);
        check("s_m7_m2_rem", {24'd0, rem}, 32'hFF);
        run_op(1'b1, 8'd7, 8'hFE, 0, lat, busy1);
        check("s_7_m2_val", {24'd0, val}, 32'hFD);
        check("s_7_m2_rem", {24'd0, rem}, 32'd1);
        run_op(1'b0, 8'hF9, 8'd2, 0, lat, busy1);
        check("u249_2_val", {24'd0, val}, 32'd124);
        check("u249_2_rem", {24'd0, rem}, 32'd1);

        // divide by zero: val/rem keep 124/1
        run_op(1'b0, 8'd5, 8'd0, 0, lat, busy1);
        check("dbz_lat",   lat, 32'd1);
        check("dbz_flags", {30'd0, dbz, ovf}, 32'd2);
        check("dbz_valid", {30'd0, valid, busy}, 32'd0);
        check("dbz_busy1", {31'd0, busy1}, 32'd0);
        check("dbz_keep",  {16'd0, val, rem}, {16'd0, 8'd124, 8'd1});
        check_pulse("dbz_pulse");

        // signed overflow -128 / -1
        run_op(1'b1, 8'h80, 8'hFF, 0, lat, busy1);
        check("ovf_lat",   lat, 32'd1);
        check("ovf_flags", {30'd0, dbz, ovf}, 32'd1);
        check("ovf_valid", {30'd0, valid, busy}, 32'd0);
        check("ovf_keep",  {16'd0, val, rem}, {16'd0, 8'd124, 8'd1});

        // second start during 200/7 is ignored
        run_op(1'b0, 8'd200, 8'd7, 2, lat, busy1);
        check("intr_lat", lat, 32'd9);
        check("intr_res", {16'd0, val, rem}, {16'd0, 8'd28, 8'd4});
        repeat (3) begin
            @(posedge clk); #1;
            check("intr_idle", {31'd0, busy}, 32'd0);
        end

        // reset at cycle 4 of an operation aborts it
        start = 1'b1; sgn = 1'b0; a = 8'd100; b = 8'd3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("abort_outs", {17'd0, busy, done, valid, dbz, ovf, val, rem}, 32'd0);
        rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            seen = seen | done | busy;
        end
        check("abort_nodone", {31'd0, seen}, 32'd0);

        // reset wins over simultaneous start
        rst = 1'b1; start = 1'b1; sgn = 1'b0; a = 8'd50; b = 8'd5;
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_start", {29'd0, busy, done, valid}, 32'd0);

        // |a| < |b|
        run_op(1'b0, 8'd3, 8'd10, 0, lat, busy1);
        check("small_lat", lat, c_SMALL_LAT);
        check("small_res", {15'd0, valid, val, rem}, {15'd0, 1'b1, 8'd0, 8'd3});
        run_op(1'b1, 8'hFD, 8'd10, 0, lat, busy1);
        check("small_neg", {15'd0, valid, val, rem}, {15'd0, 1'b1, 8'd0, 8'hFD});

        // boundaries
        run_op(1'b0, 8'd255, 8'd1, 0, lat, busy1);
        check("u255_1", {15'd0, valid, val, rem}, {15'd0, 1'b1, 8'd255, 8'd0});
        run_op(1'b1, 8'h80, 8'd1, 0, lat, busy1);
        check("s_m128_1", {15'd0, valid, val, rem}, {15'd0, 1'b1, 8'h80, 8'd0});
        run_op(1'b0, 8'd255, 8'd255, 0, lat, busy1);
        check("u255_255", {16'd0, val, rem}, {16'd0, 8'd1, 8'd0});

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
